// File: rtl/dual_fetch_queue_pkg.sv
// Shared types and constants for the dual-issue fetch path.
// Queue entries carry the fetch PC alongside the instruction word.
package dual_issue_pkg;

  localparam logic [31:0] NOP_INST     = 32'h0;
  localparam logic [31:0] FETCH_STRIDE = 32'd8;
  localparam logic [31:0] INST_BYTES   = 32'd4;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    SQUASH
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } q_entry_t;

endpackage

// File: rtl/dual_fetch_queue_if.sv
// Bundle of the instruction-memory bus and the dual-issue presentation signals.
// master: the fetch queue; slave: memory plus issue stage.
interface dual_fetch_queue_if #(
  parameter int unsigned QDEPTH = 4
);
  localparam int unsigned CNT_W = $clog2(QDEPTH) + 1;

  logic             stall;
  logic             rewind;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             imem_req;
  logic [31:0]      imem_addr;
  logic [31:0]      imem_rdata0;
  logic [31:0]      imem_rdata1;
  logic [31:0]      inst0_old;
  logic [31:0]      inst1_old;
  logic [31:0]      pc0_out;
  logic [31:0]      pc1_out;
  logic [CNT_W-1:0] q_count;

  modport master (
    input  stall, rewind, redirect_valid, redirect_pc, imem_rdata0, imem_rdata1,
    output imem_req, imem_addr, inst0_old, inst1_old, pc0_out, pc1_out, q_count
  );

  modport slave (
    output stall, rewind, redirect_valid, redirect_pc, imem_rdata0, imem_rdata1,
    input  imem_req, imem_addr, inst0_old, inst1_old, pc0_out, pc1_out, q_count
  );

endinterface

// File: rtl/dual_fetch_queue_fetch_queue.sv
// Circular buffer accepting up to two pushes and two pops per cycle.
// Exposes the two oldest entries; flush empties it by snapping head to tail.
module fetch_queue
  import dual_issue_pkg::*;
#(
  parameter int unsigned QDEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic [1:0]             push_cnt,
  input  q_entry_t               push0,
  input  q_entry_t               push1,
  input  logic [1:0]             pop_cnt,
  output q_entry_t               head0,
  output q_entry_t               head1,
  output logic [$clog2(QDEPTH):0] count
);

  localparam int unsigned PW = $clog2(QDEPTH);
  localparam int unsigned CW = PW + 1;

  q_entry_t      mem [QDEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW-1:0] head_p1;
  logic [PW-1:0] tail_p1;

  assign head_p1 = head + 1'b1;
  assign tail_p1 = tail + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= tail;
      count <= '0;
    end else begin
      head  <= head + PW'(pop_cnt);
      tail  <= tail + PW'(push_cnt);
      count <= count + CW'(push_cnt) - CW'(pop_cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !flush && push_cnt != 2'd0) begin
      mem[tail] <= push0;
      if (push_cnt == 2'd2) mem[tail_p1] <= push1;
    end
  end

  assign head0 = mem[head];
  assign head1 = mem[head_p1];

endmodule

// File: rtl/dual_fetch_queue.sv
// Fetch unit feeding the dual-issue stage: BOOT/RUN/SQUASH FSM, fetch PC and
// request throttling around fetch_queue. `define FETCH_PERF_CNT_EN adds perf counters.
module dual_fetch_queue
  import dual_issue_pkg::*;
#(
  parameter int unsigned QDEPTH   = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset,
  dual_fetch_queue_if.master bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        perf_rewind_cnt,
  output logic [31:0]        perf_empty_cnt
`endif
);

  localparam int unsigned CW = $clog2(QDEPTH) + 1;

  fetch_state_t  state;
  fetch_state_t  state_next;
  logic [31:0]   fetch_pc;
  logic [31:0]   req_pc;
  logic          inflight;
  logic          req;
  logic          room;
  logic          redirect;
  logic [1:0]    push_cnt;
  logic [1:0]    pop_cnt;
  logic [CW-1:0] count;
  q_entry_t      head0;
  q_entry_t      head1;
  q_entry_t      push0;
  q_entry_t      push1;
  logic          valid0;
  logic          valid1;

  assign redirect = bus.redirect_valid && !reset;
  // Counting the outstanding pair as already queued keeps pushes from overrunning.
  assign room = (32'(count) + (inflight ? 32'd2 : 32'd0)) <= (QDEPTH - 32'd2);

  always_comb begin
    state_next = state;
    req        = 1'b0;
    push_cnt   = 2'd0;
    pop_cnt    = 2'd0;
    case (state)
      BOOT:    state_next = RUN;
      RUN:     state_next = RUN;
      SQUASH:  state_next = RUN;
      default: state_next = BOOT;
    endcase
    if (redirect) state_next = SQUASH;
    if (!reset && state != BOOT && !redirect && room) req = 1'b1;
    if (!reset && inflight && !redirect) push_cnt = 2'd2;
    if (!reset && !redirect && !bus.stall) begin
      if (count >= CW'(2))      pop_cnt = bus.rewind ? 2'd1 : 2'd2;
      else if (count == CW'(1)) pop_cnt = 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= BOOT;
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
      inflight <= 1'b0;
    end else begin
      state    <= state_next;
      inflight <= req;
      if (redirect) begin
        fetch_pc <= bus.redirect_pc & ~32'h3;
      end else if (req) begin
        req_pc   <= fetch_pc;
        fetch_pc <= fetch_pc + FETCH_STRIDE;
      end
    end
  end

  assign push0 = '{pc: req_pc,              inst: bus.imem_rdata0};
  assign push1 = '{pc: req_pc + INST_BYTES, inst: bus.imem_rdata1};

  fetch_queue #(
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk      (clk),
    .reset    (reset),
    .flush    (redirect),
    .push_cnt (push_cnt),
    .push0    (push0),
    .push1    (push1),
    .pop_cnt  (pop_cnt),
    .head0    (head0),
    .head1    (head1),
    .count    (count)
  );

  assign valid0 = !reset && count != '0;
  assign valid1 = !reset && count >= CW'(2);

  assign bus.imem_req  = req;
  assign bus.imem_addr = reset ? '0 : fetch_pc;
  assign bus.inst0_old = valid0 ? head0.inst : NOP_INST;
  assign bus.inst1_old = valid1 ? head1.inst : NOP_INST;
  assign bus.pc0_out   = valid0 ? head0.pc : '0;
  assign bus.pc1_out   = valid1 ? head1.pc : '0;
  assign bus.q_count   = reset ? '0 : count;

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_rewind_cnt <= '0;
      perf_empty_cnt  <= '0;
    end else begin
      if (!redirect && !bus.stall && bus.rewind && count >= CW'(2))
        perf_rewind_cnt <= perf_rewind_cnt + 32'd1;
      if (count == '0 && state != BOOT)
        perf_empty_cnt <= perf_empty_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dual_fetch_queue.sv
// Randomized bench for dual_fetch_queue against a queue-based reference model.
module tb_dual_fetch_queue;

  localparam int unsigned QD = 4;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  dual_fetch_queue_if #(.QDEPTH(QD)) bus ();

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_rewind_cnt;
  logic [31:0] perf_empty_cnt;
`endif

  dual_fetch_queue #(
    .QDEPTH   (QD),
    .RESET_PC (RPC)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_rewind_cnt (perf_rewind_cnt),
    .perf_empty_cnt  (perf_empty_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A00_0000;
  endfunction

  // Synchronous memory: one-cycle read latency, garbage when not requested.
  always @(posedge clk) begin
    if (bus.imem_req) begin
      bus.imem_rdata0 <= mem_word(bus.imem_addr);
      bus.imem_rdata1 <= mem_word(bus.imem_addr + 32'd4);
    end else begin
      bus.imem_rdata0 <= $urandom;
      bus.imem_rdata1 <= $urandom;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: entries are {pc, inst} in fetch order.
  logic [63:0] mq[$];
  bit          m_boot;
  bit          m_inflight;
  logic [31:0] m_pc;
  logic [31:0] m_req_pc;
  int          m_rew;
  int          m_empty;

  task automatic step(input bit rst, input bit st, input bit rw, input bit rd,
                      input logic [31:0] rpc);
    int sz;
    int n;
    bit e_req;
    reset              = rst;
    bus.stall          = st;
    bus.rewind         = rw;
    bus.redirect_valid = rd;
    bus.redirect_pc    = rpc;
    @(negedge clk);
    sz    = mq.size();
    e_req = !rst && !m_boot && !rd && (sz + (m_inflight ? 2 : 0) <= int'(QD) - 2);
    check_eq("imem_req",  32'(bus.imem_req), 32'(e_req));
    check_eq("imem_addr", bus.imem_addr, rst ? 32'h0 : m_pc);
    check_eq("inst0_old", bus.inst0_old, (!rst && sz >= 1) ? mq[0][31:0]  : 32'h0);
    check_eq("pc0_out",   bus.pc0_out,   (!rst && sz >= 1) ? mq[0][63:32] : 32'h0);
    check_eq("inst1_old", bus.inst1_old, (!rst && sz >= 2) ? mq[1][31:0]  : 32'h0);
    check_eq("pc1_out",   bus.pc1_out,   (!rst && sz >= 2) ? mq[1][63:32] : 32'h0);
    check_eq("q_count",   32'(bus.q_count), rst ? 32'h0 : 32'(sz));
`ifdef FETCH_PERF_CNT_EN
    if (!rst) begin
      check_eq("perf_rewind", perf_rewind_cnt, 32'(m_rew));
      check_eq("perf_empty",  perf_empty_cnt,  32'(m_empty));
    end
`endif
    if (rst) begin
      mq.delete();
      m_pc       = RPC;
      m_inflight = 1'b0;
      m_boot     = 1'b1;
      m_rew      = 0;
      m_empty    = 0;
    end else begin
      if (!m_boot && sz == 0) m_empty++;
      if (rd) begin
        mq.delete();
        m_pc       = rpc & ~32'h3;
        m_inflight = 1'b0;
      end else begin
        if (!st) begin
          n = (sz >= 2) ? (rw ? 1 : 2) : sz;
          if (sz >= 2 && rw) m_rew++;
          repeat (n) void'(mq.pop_front());
        end
        if (m_inflight) begin
          mq.push_back({m_req_pc, mem_word(m_req_pc)});
          mq.push_back({m_req_pc + 32'd4, mem_word(m_req_pc + 32'd4)});
        end
        if (e_req) begin
          m_req_pc = m_pc;
          m_pc     = m_pc + 32'd8;
        end
        m_inflight = e_req;
      end
      m_boot = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    m_boot  = 1'b1;
    repeat (2) step(1, 0, 0, 0, 32'h0);
    repeat (12) step(0, 0, 0, 0, 32'h0);
    step(0, 0, 1, 0, 32'h0);
    repeat (20) step(0, 0, 0, 0, 32'h0);
    repeat (6) step(0, 1, 0, 0, 32'h0);
    repeat (4) step(0, 0, 0, 0, 32'h0);
    step(0, 0, 0, 1, 32'h0000_0040);
    repeat (6) step(0, 0, 0, 0, 32'h0);
    step(0, 1, 1, 1, 32'h0000_0103);
    repeat (6) step(0, 0, 0, 0, 32'h0);
    step(0, 0, 0, 1, 32'h0000_0200);
    step(0, 0, 0, 1, 32'h0000_0300);
    repeat (6) step(0, 0, 0, 0, 32'h0);
    repeat (5) begin
      step(0, 0, 1, 0, 32'h0);
      step(0, 0, 0, 0, 32'h0);
    end
    repeat (600) begin
      step(($urandom % 100) == 0, ($urandom % 4) == 0, ($urandom % 3) == 0,
           ($urandom % 25) == 0, $urandom);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dual_fetch_queue.md
Name: dual_fetch_queue

Overview:
- Producer side of the dual-issue interface. Fetches two sequential instructions per request from a synchronous instruction memory and buffers them in a small circular queue.
- Presents the two oldest entries as inst0_old/inst1_old to the dual-issue stage.
- Pops 2 entries per cycle, or 1 when the issue stage asserts rewind (slot 1 not consumed, so it becomes next cycle's slot 0).
- Handles branch/jump redirects by flushing the queue and squashing in-flight memory responses.

Parameters:
- QDEPTH, 4, queue entries; power of two, minimum 4.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- stall  in  1  hold outputs; no pop this cycle
- rewind  in  1  issue consumed slot 0 only
- redirect_valid  in  1  branch/jump taken; highest priority
- redirect_pc  in  32  new fetch address; bits [1:0] ignored
- imem_req  out  1  read request, combinational from state
- imem_addr  out  32  word address of slot A; memory returns A and A+4
- imem_rdata0  in  32  instruction at A, valid the cycle after imem_req
- imem_rdata1  in  32  instruction at A+4, same timing
- inst0_old  out  32  queue head, or 32'h0 (NOP) if count==0
- inst1_old  out  32  head+1, or 32'h0 if count<2
- pc0_out  out  32  PC of inst0_old (0 when invalid)
- pc1_out  out  32  PC of inst1_old (0 when invalid)
- q_count  out  3  current occupancy, 0..QDEPTH

Behaviour:
- Reset (synchronous, active-high):
  - fetch_pc=RESET_PC; count=0; head=tail=0; inflight=0.
  - All outputs 0; imem_req=0 during reset.
- State machine, registered:
  - BOOT: one cycle after reset deasserts; no request; then RUN.
  - RUN: normal operation.
  - SQUASH: entered on redirect.
- Request rule (RUN):
  - imem_req=1 when !redirect_valid && (count + 2*inflight) <= QDEPTH-2.
  - imem_addr=fetch_pc. On request, fetch_pc+=8 and inflight is set for the next cycle.
- Response (one-cycle latency): when inflight==1 and not squashed, push {pc,rdata0} then {pc+4,rdata1} at tail; tail+=2 mod QDEPTH.
- Pop rule, when !stall:
  - count>=2: pop 2, or 1 if rewind.
  - count==1: pop 1; rewind ignored.
  - count==0: no pop.
  - stall=1: no pop; outputs hold.
- Simultaneous push and pop in one cycle: count_next = count + push - pop. Never exceeds QDEPTH (guaranteed by the request rule). Pointers wrap mod QDEPTH.
- Redirect (cycle t):
  - count=0; head=tail; fetch_pc=redirect_pc & ~3.
  - Responses arriving at t and t+1 are discarded. State goes to SQUASH at t+1; a request at redirect_pc is issued at t+1; state returns to RUN at t+2.
  - Redirect beats stall and rewind. Redirect during SQUASH restarts SQUASH with the new PC.
- Outputs combinational from queue state: first valid instruction at inst0_old 2 cycles after the first request.
- Reset mid-operation: all state reinitialised next edge; in-flight responses ignored.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: adds outputs perf_rewind_cnt[31:0] and perf_empty_cnt[31:0].
  - perf_rewind_cnt increments on each accepted rewind.
  - perf_empty_cnt increments each cycle with count==0 while not in BOOT.
  - Both cleared by reset, wrap at 2^32.
- Undefined: ports and counters absent; core behaviour identical.

Decomposition:
- Shared package dual_issue_pkg:
  - NOP_INST=32'h0
  - FETCH_STRIDE=8, INST_BYTES=4
  - state encodings BOOT/RUN/SQUASH
  - queue-entry typedef {pc[31:0], inst[31:0]}
- Sub-module fetch_queue: 2-push/2-pop circular buffer exposing head, head+1, count, push/pop_cnt and flush. Top level holds the FSM, PC and request logic.

Test Plan:
- Reset, RESET_PC=0, imem returns addr-derived words → imem_addr 0,8,16…; inst0_old/inst1_old = words at 0/4, then 8/12; q_count never >4.
- Rewind held 1 cycle when head pair is PC 0x8/0xC → next cycle pc0_out=0xC, pc1_out=0x10; no instruction lost or duplicated over 20 cycles.
- Stall 3 cycles with a full queue → outputs unchanged, imem_req=0, q_count=4; release → pairs resume in order.
- redirect_valid with redirect_pc=0x40 while a response is in flight → q_count=0 next cycle; first valid pair PC 0x40/0x44; stale words never appear.
- Simultaneous redirect, rewind and stall → redirect wins; rewind and stall ignored that cycle.
- With FETCH_PERF_CNT_EN: 5 rewinds plus BOOT-excluded empty cycles → perf_rewind_cnt=5, perf_empty_cnt matches the cycles with q_count==0.
